// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall, EX redirect flush and operand forwarding control.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush event counters.
module pipe_hazard_unit #(
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    localparam int FW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_ad,
    input  logic [REG_AW-1:0] id_rs2_ad,
    input  logic              id_rs1_read,
    input  logic              id_rs2_read,
    input  logic [REG_AW-1:0] id_rd_ad,
    input  logic              id_rdEn,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              flush_ifid,
    output logic              ex_bubble,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic              ex_valid,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              en;
        logic              ld;
    } slot_t;

    slot_t slot [DEPTH];
    logic load_use, stall, flush, enter, unused_wb;
    logic [FW-1:0] nxt_a, nxt_b;

    function automatic logic hit(input slot_t e, input logic [REG_AW-1:0] s, input logic r);
        return e.v && e.en && (e.rd == s) && r && (s != '0);
    endfunction

    // Walk from the oldest forwardable slot down so the youngest producer wins.
    always_comb begin
        load_use = 1'b0;
        nxt_a = '0;
        nxt_b = '0;
        for (int k = 0; k < LOAD_LAT; k++)
            load_use = load_use | (slot[k].ld &&
                (hit(slot[k], id_rs1_ad, id_rs1_read) || hit(slot[k], id_rs2_ad, id_rs2_read)));
        for (int j = DEPTH - 1; j >= 1; j--) begin
            nxt_a = hit(slot[j-1], id_rs1_ad, id_rs1_read) ? FW'(j) : nxt_a;
            nxt_b = hit(slot[j-1], id_rs2_ad, id_rs2_read) ? FW'(j) : nxt_b;
        end
    end

    assign flush      = !reset && ex_redirect;
    assign stall      = !reset && id_valid && load_use && !ex_redirect;
    assign enter      = id_valid && !stall && !flush;
    assign pc_hold    = stall;
    assign ifid_hold  = stall;
    assign flush_ifid = flush;
    assign ex_bubble  = stall || flush;
    assign ex_valid   = slot[0].v;
    // The WB entry is never consulted: the register file is write-first.
    assign unused_wb  = ^slot[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
            fwd_a <= '0;
            fwd_b <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) slot[k] <= slot[k-1];
            slot[0] <= enter ? {1'b1, id_rd_ad, id_rdEn, id_is_load} : '0;
            fwd_a   <= enter ? nxt_a : '0;
            fwd_b   <= enter ? nxt_b : '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (flush_ifid && !(&flush_cnt)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
